// File: rtl/seq_det_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_det_bit_serializer
//
// Parallel-to-serial front end for the sequence detectors. Words arrive over a
// valid/ready handshake and leave one bit per clock on Bit_Out. Bit_Valid marks
// each fresh bit and doubles as the detector's clock-enable. A new word can be
// taken on the cycle that carries the last bit of the current one, so
// back-to-back words form one contiguous bit stream. Patterns that straddle a
// word boundary therefore stay visible to the detector.
//
// Parameters
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  1: Data_In[WIDTH-1] goes out first, 0: Data_In[0] goes out first
//   CW         width of Bit_Cnt
//
// Ports
//   Clk         in   clock, rising edge
//   Rst         in   synchronous active-low reset
//   Data_In     in   word to serialize, captured only on accept
//   Data_Valid  in   upstream offers a word
//   Data_Ready  out  serializer can take a word this cycle
//   Stall       in   downstream hold, freezes shifting
//   Bit_Out     out  current serial bit (registered)
//   Bit_Valid   out  Bit_Out is a new bit this cycle
//   Busy        out  a word is being shifted
//   Bit_Cnt     out  index of the current bit within its word
//   Word_Done   out  pulse on the cycle carrying the last bit of a word
// -----------------------------------------------------------------------------
module seq_det_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Data_In,
  input  logic             Data_Valid,
  output logic             Data_Ready,
  input  logic             Stall,
  output logic             Bit_Out,
  output logic             Bit_Valid,
  output logic             Busy,
  output logic [CW-1:0]    Bit_Cnt,
  output logic             Word_Done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             bit_q, bit_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             last_bit;
  logic             ready;

  // The bit that leaves first from a word, given the shift direction.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST)
      return w[WIDTH-1];
    else
      return w[0];
  endfunction

  // Move the next bit to the lead position; the vacated end fills with 0.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST)
      return w << 1;
    else
      return w >> 1;
  endfunction

  assign last_bit = (cnt == LAST_IDX);

  // ---------------------------------------------------------------------------
  // Next-state and handshake logic
  // ---------------------------------------------------------------------------
  // The shift register holds only the bits not yet presented: on a load the
  // first bit goes straight to Bit_Out and the register keeps the remainder,
  // so the next bit is always lead_bit(shreg).
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    bit_nxt   = bit_q;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    Bit_Valid = 1'b0;
    Word_Done = 1'b0;

    unique case (state)
      IDLE: begin
        // Stall has no influence while idle.
        ready = Rst;
        if (Data_Valid && Rst) begin
          shreg_nxt = advance(Data_In);
          bit_nxt   = lead_bit(Data_In);
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        // A stalled cycle holds everything and blocks both the accept and
        // Word_Done on the last bit.
        if (!Stall) begin
          Bit_Valid = 1'b1;
          if (last_bit) begin
            Word_Done = 1'b1;
            ready     = Rst;
            if (Data_Valid && Rst) begin
              // Reload without a bubble so the bit stream stays contiguous.
              shreg_nxt = advance(Data_In);
              bit_nxt   = lead_bit(Data_In);
              cnt_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            shreg_nxt = advance(shreg);
            bit_nxt   = lead_bit(shreg);
            cnt_nxt   = cnt + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // Reset mid-word drops the remaining bits; Word_Done is combinational on the
  // SHIFT state, so an aborted word never produces one.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
      shreg <= '0;
      bit_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      bit_q <= bit_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign Data_Ready = ready;
  assign Bit_Out    = bit_q;
  assign Busy       = (state == SHIFT);
  assign Bit_Cnt    = cnt;

endmodule

// File: tb/tb_seq_det_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_det_bit_serializer
//
// Directed bench for seq_det_bit_serializer. Three instances share clock,
// reset and stall: an 8-bit MSB-first unit, an 8-bit LSB-first unit and a
// 4-bit MSB-first unit whose stream feeds a small overlapping 1010 detector.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_seq_det_bit_serializer;

  logic Clk;
  logic Rst;
  logic Stall;

  // 8-bit MSB-first instance
  logic [7:0] d8;
  logic       dv8, rdy8, bit8, bv8, busy8, wd8;
  logic [2:0] cnt8;

  // 8-bit LSB-first instance
  logic [7:0] dl;
  logic       dvl, rdyl, bitl, bvl, busyl, wdl;
  logic [2:0] cntl;

  // 4-bit MSB-first instance
  logic [3:0] d4;
  logic       dv4, rdy4, bit4, bv4, busy4, wd4;
  logic [1:0] cnt4;

  int n_chk;
  int n_pass;

  seq_det_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .Clk(Clk), .Rst(Rst), .Data_In(d8), .Data_Valid(dv8), .Data_Ready(rdy8),
    .Stall(Stall), .Bit_Out(bit8), .Bit_Valid(bv8), .Busy(busy8),
    .Bit_Cnt(cnt8), .Word_Done(wd8)
  );

  seq_det_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .Clk(Clk), .Rst(Rst), .Data_In(dl), .Data_Valid(dvl), .Data_Ready(rdyl),
    .Stall(Stall), .Bit_Out(bitl), .Bit_Valid(bvl), .Busy(busyl),
    .Bit_Cnt(cntl), .Word_Done(wdl)
  );

  seq_det_bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_w4 (
    .Clk(Clk), .Rst(Rst), .Data_In(d4), .Data_Valid(dv4), .Data_Ready(rdy4),
    .Stall(Stall), .Bit_Out(bit4), .Bit_Valid(bv4), .Busy(busy4),
    .Bit_Cnt(cnt4), .Word_Done(wd4)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Overlapping 1010 detector advancing only on Bit_Valid of the 4-bit unit.
  logic [2:0] hist;
  int         det_cnt;
  always @(posedge Clk) begin
    if (!Rst) begin
      hist    <= '0;
      det_cnt <= 0;
    end else if (bv4) begin
      hist <= {hist[1:0], bit4};
      if ({hist, bit4} == 4'b1010)
        det_cnt <= det_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic next_cyc();
    @(posedge Clk);
    #1;
  endtask

  // Offer w to the MSB-first unit in the current cycle and follow all 8 bits.
  task automatic send8(input string tag, input logic [7:0] w);
    dv8 = 1'b1;
    d8  = w;
    @(negedge Clk);
    chk({tag, "_rdy"}, 32'(rdy8), 32'd1);
    next_cyc();
    dv8 = 1'b0;
    d8  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      chk({tag, "_bit"}, 32'(bit8), 32'(w[7-i]));
      chk({tag, "_bv"},  32'(bv8),  32'd1);
      chk({tag, "_cnt"}, 32'(cnt8), 32'(i));
      chk({tag, "_wd"},  32'(wd8),  32'(i == 7));
      next_cyc();
    end
    @(negedge Clk);
    chk({tag, "_idle_busy"}, 32'(busy8), 32'd0);
    chk({tag, "_idle_rdy"},  32'(rdy8),  32'd1);
    chk({tag, "_idle_bv"},   32'(bv8),   32'd0);
    next_cyc();
  endtask

  logic [15:0] b2b;
  int          stall_cnt [10];
  logic [3:0]  junk [3];

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    Rst     = 1'b0;
    Stall   = 1'b0;
    dv8 = 1'b0; d8 = '0;
    dvl = 1'b0; dl = '0;
    dv4 = 1'b0; d4 = '0;

    // Reset held for two edges; Data_Ready forced low meanwhile.
    @(negedge Clk);
    chk("rst_rdy_low", 32'(rdy8), 32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(negedge Clk);
    chk("rst_bit",  32'(bit8),  32'd0);
    chk("rst_bv",   32'(bv8),   32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_cnt",  32'(cnt8),  32'd0);
    chk("rst_wd",   32'(wd8),   32'd0);
    chk("rst_rdy",  32'(rdy8),  32'd1);
    next_cyc();

    // Single word 1010_1100.
    send8("single", 8'b1010_1100);

    // Back-to-back A5 then 0F with Data_Valid held high.
    b2b = 16'b1010_0101_0000_1111;
    dv8 = 1'b1;
    d8  = 8'hA5;
    @(negedge Clk);
    chk("b2b_rdy0", 32'(rdy8), 32'd1);
    next_cyc();
    d8 = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      chk("b2b_bit",  32'(bit8),  32'(b2b[15-i]));
      chk("b2b_bv",   32'(bv8),   32'd1);
      chk("b2b_busy", 32'(busy8), 32'd1);
      chk("b2b_cnt",  32'(cnt8),  32'(i % 8));
      chk("b2b_rdy",  32'(rdy8),  32'((i % 8) == 7));
      chk("b2b_wd",   32'(wd8),   32'((i % 8) == 7));
      next_cyc();
      if (i == 7) begin
        dv8 = 1'b0;
        d8  = 8'h00;
      end
    end
    @(negedge Clk);
    chk("b2b_idle", 32'(busy8), 32'd0);
    next_cyc();

    // Stall in cycles k+3 and k+4 during F0; last bit lands at k+10.
    stall_cnt = '{0, 1, 2, 2, 2, 3, 4, 5, 6, 7};
    dv8 = 1'b1;
    d8  = 8'hF0;
    next_cyc();
    dv8 = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      Stall = (j == 3 || j == 4);
      @(negedge Clk);
      chk("stall_bv",  32'(bv8),  32'(!(j == 3 || j == 4)));
      chk("stall_cnt", 32'(cnt8), 32'(stall_cnt[j-1]));
      chk("stall_bit", 32'(bit8), 32'(stall_cnt[j-1] < 4));
      chk("stall_rdy", 32'(rdy8), 32'(j == 10));
      chk("stall_wd",  32'(wd8),  32'(j == 10));
      next_cyc();
    end
    Stall = 1'b0;
    @(negedge Clk);
    chk("stall_idle", 32'(busy8), 32'd0);
    next_cyc();

    // LSB-first: 8'h01 gives 1 then seven 0s.
    dvl = 1'b1;
    dl  = 8'h01;
    next_cyc();
    dvl = 1'b0;
    dl  = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      chk("lsb_bit", 32'(bitl), 32'(i == 0));
      chk("lsb_bv",  32'(bvl),  32'd1);
      chk("lsb_wd",  32'(wdl),  32'(i == 7));
      next_cyc();
    end

    // Reset at the k+4 edge while shifting FF.
    dv8 = 1'b1;
    d8  = 8'hFF;
    next_cyc();
    dv8 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge Clk);
      chk("mid_bit", 32'(bit8), 32'd1);
      next_cyc();
    end
    Rst = 1'b0;
    @(negedge Clk);
    chk("mid_rst_rdy", 32'(rdy8), 32'd0);
    next_cyc();
    Rst = 1'b1;
    @(negedge Clk);
    chk("mid_busy", 32'(busy8), 32'd0);
    chk("mid_bv",   32'(bv8),   32'd0);
    chk("mid_cnt",  32'(cnt8),  32'd0);
    chk("mid_bit0", 32'(bit8),  32'd0);
    chk("mid_wd",   32'(wd8),   32'd0);
    next_cyc();
    send8("after_rst", 8'hC3);

    // 4-bit unit: Data_Valid held high with junk on Data_In except at the
    // last-bit cycles, where 1010 is offered again.
    junk = '{4'b0101, 4'b1111, 4'b0000};
    dv4 = 1'b1;
    d4  = 4'b1010;
    next_cyc();
    for (int w = 0; w < 3; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 3) begin
          d4  = 4'b1010;
          dv4 = (w < 2);
        end else begin
          d4  = junk[b];
          dv4 = 1'b1;
        end
        @(negedge Clk);
        chk("w4_bit", 32'(bit4), 32'((b % 2) == 0));
        chk("w4_bv",  32'(bv4),  32'd1);
        chk("w4_cnt", 32'(cnt4), 32'(b));
        chk("w4_rdy", 32'(rdy4), 32'(b == 3));
        next_cyc();
      end
    end
    dv4 = 1'b0;
    @(negedge Clk);
    chk("w4_idle", 32'(busy4), 32'd0);
    chk("w4_det",  32'(det_cnt), 32'd5);
    next_cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_det_bit_serializer.md
# seq_det_bit_serializer

Parallel-to-serial front end for the sequence detectors. It accepts WIDTH-bit words through a valid/ready handshake and shifts them out one bit per clock on Bit_Out, which drives the detector's In. Bit_Valid qualifies each bit and acts as the detector's clock-enable. Consecutive words are streamed with no bubble, so overlapping patterns that span a word boundary are still detected.

## Interface
- WIDTH, 8: word width in bits, legal range 2..32.
- MSB_FIRST, 1: 1 shifts Data_In[WIDTH-1] first; 0 shifts Data_In[0] first.
- CW, $clog2(WIDTH): width of Bit_Cnt.

- Clk  input  1  clock; everything is updated on the rising edge.
- Rst  input  1  synchronous, active-low reset, sampled on the rising edge of Clk.
- Data_In  input  WIDTH  word to serialize; sampled only on an accept.
- Data_Valid  input  1  upstream has a word on Data_In.
- Data_Ready  output  1  serializer can take a word this cycle.
- Stall  input  1  downstream hold; freezes shifting.
- Bit_Out  output  1  current serial bit (registered).
- Bit_Valid  output  1  Bit_Out is a new bit this cycle.
- Busy  output  1  a word is being shifted.
- Bit_Cnt  output  CW  index of the current bit within its word, 0..WIDTH-1.
- Word_Done  output  1  one-cycle pulse on the last bit of each word.

## Operation
- **Accept** is defined as Data_Valid & Data_Ready at a rising edge.
- **States:** IDLE = 0, SHIFT = 1.
- **IDLE:**
  - Data_Ready = 1.
  - On accept: load shift register, Bit_Cnt <= 0, go to SHIFT.
  - Bit_Out is loaded with the first bit of the word (MSB or LSB per MSB_FIRST).
- **SHIFT with Stall = 1:**
  - Shift register, Bit_Cnt, Bit_Out and state all hold.
  - Bit_Valid = 0, Data_Ready = 0, Word_Done = 0.
- **SHIFT with Stall = 0 and Bit_Cnt < WIDTH-1:**
  - Shift one position and present the next bit.
  - Bit_Cnt <= Bit_Cnt + 1.
- **SHIFT with Stall = 0 and Bit_Cnt == WIDTH-1 (last bit):**
  - Word_Done = 1, Data_Ready = 1.
  - On accept: load the new word, Bit_Cnt <= 0, stay in SHIFT (no bubble).
  - Otherwise: go to IDLE.
- **Combinational outputs:**
  - Bit_Valid = (state == SHIFT) & ~Stall.
  - Busy = (state == SHIFT).
  - Data_Ready = Rst & ((state == IDLE) | (state == SHIFT & Bit_Cnt == WIDTH-1 & ~Stall)).
- **Word capture and hold:**
  - Data_In is captured only on accept.
  - While Data_Ready = 0, Data_Valid is ignored and the word is not consumed. Upstream holds it.
- **Reset (Rst low at an edge):** state <= IDLE, shift register <= 0, Bit_Out <= 0, Bit_Cnt <= 0.
  - Data_Ready is forced to 0 in any cycle where Rst is low.
- **Reset mid-word:** the remaining bits are discarded. No Word_Done is issued for the aborted word.
- **Stall in IDLE:** no effect. Accept still proceeds.
- **Stall on the last-bit cycle:** blocks both the accept and Word_Done until Stall drops.

## Timing
- **Reset values, first cycle after reset:** Bit_Out 0, Bit_Valid 0, Busy 0, Bit_Cnt 0, Word_Done 0, Data_Ready 1.
- **Latency:** for an accept at edge k, the first bit is on Bit_Out with Bit_Valid = 1 in cycle k+1.
  - With no stalls, the last bit appears in cycle k+WIDTH.
- **Throughput:** one bit per unstalled cycle. Back-to-back words give a contiguous Bit_Valid stream.
- **Stalls:** each Stall cycle inside a word adds exactly one cycle to that word.
- **Word_Done:** coincides with the cycle carrying the last bit and its Bit_Valid.
- **Downstream sampling:** the detector must advance only on cycles where Bit_Valid = 1.

## Test plan
- **Reset, single word:** Rst low for 2 cycles, then 8'b1010_1100 accepted at edge k (MSB_FIRST = 1).
  - Required: Bit_Out 1,0,1,0,1,1,0,0 in cycles k+1..k+8.
  - Bit_Valid = 1 throughout those cycles; Word_Done only at k+8.
  - IDLE at k+9 with Data_Ready = 1.
- **Back-to-back words:** 8'hA5 then 8'h0F, Data_Valid held high.
  - Required: 16 contiguous valid bits 1010_0101_0000_1111.
  - Second accept occurs at the k+8 edge; Busy never drops.
- **Stall mid-word:** Stall high in cycles k+3 and k+4 during 8'hF0.
  - Required: Bit_Valid = 0 and Bit_Out/Bit_Cnt frozen in those cycles.
  - Last bit at k+10; Data_Ready low until k+10.
- **LSB-first:** MSB_FIRST = 0, Data_In = 8'h01.
  - Required: Bit_Out 1 then seven 0s.
- **Reset mid-word:** Rst low at the k+4 edge.
  - Required next cycle: Busy 0, Bit_Valid 0, Bit_Cnt 0, Bit_Out 0.
  - No Word_Done; the next word is serialized from its first bit.
- **Ignored Data_Valid:** Data_Valid held high with Data_In changing while Busy and not on the last bit.
  - Required: no capture; only values present at accept edges appear on Bit_Out.
  - Concatenating 4'b1010 words on the stream drives the downstream 1010 detector to assert on each overlap.
